instr_fetch_queue: RTL

//  Parametrised fetch front-end that supersedes the PC/PCAddr/IR trio of the multicycle chip.

---
 rtl/instr_fetch_queue.sv | 120 ++++++++++++
 1 files changed

// File: rtl/instr_fetch_queue.sv
// Fetch front-end: issues reads to a fixed-latency instruction ROM, tags them with their PC,
// and queues returned words in a small FIFO presented to decode via valid/ready.
module instr_fetch_queue #(
    parameter int                DATA_W   = 32,
    parameter int                ADDR_W   = 32,
    parameter int                DEPTH    = 4,
    parameter int                LAT      = 1,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic                         clk,
    input  logic                         rst,
    output logic                         imem_en,
    output logic [ADDR_W-1:0]            imem_addr,
    input  logic [DATA_W-1:0]            imem_rdata,
    input  logic                         redirect,
    input  logic [ADDR_W-1:0]            redirect_pc,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [DATA_W-1:0]            out_instr,
    output logic [ADDR_W-1:0]            out_pc,
    output logic [ADDR_W-1:0]            out_pc4,
    output logic [$clog2(DEPTH+1)-1:0]   level
);

    localparam int LW = $clog2(DEPTH + 1);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int OW = LW + 1;

    logic [ADDR_W-1:0] fetch_pc_q, fetch_pc_d;
    logic [LAT-1:0]    tvld_q, tvld_d;
    logic [ADDR_W-1:0] tpc_q [LAT];
    logic [ADDR_W-1:0] tpc_d [LAT];
    logic [PW-1:0]     wr_q, wr_d, rd_q, rd_d;
    logic [LW-1:0]     cnt_q, cnt_d;
    logic [DATA_W-1:0] mem_instr [DEPTH];
    logic [ADDR_W-1:0] mem_pc [DEPTH];
    logic [OW-1:0]     inflight;
    logic              issue, push, pop;
    logic              unused_pc_lsb;

    assign unused_pc_lsb = ^redirect_pc[1:0];

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    always_comb begin
        inflight = '0;
        for (int i = 0; i < LAT; i++) inflight = inflight + OW'(tvld_q[i]);
    end

    // Credit counts both stored and in-flight words so a return can never find the FIFO full.
    assign issue     = !rst && !redirect && ((OW'(cnt_q) + inflight) < OW'(DEPTH));
    assign push      = tvld_q[LAT-1] && !redirect;
    assign out_valid = (cnt_q != '0);
    assign pop       = out_valid && out_ready;

    always_comb begin
        fetch_pc_d = fetch_pc_q;
        tvld_d[0]  = issue;
        tpc_d[0]   = fetch_pc_q;
        for (int i = 1; i < LAT; i++) begin
            tvld_d[i] = tvld_q[i-1];
            tpc_d[i]  = tpc_q[i-1];
        end
        wr_d  = push ? ptr_inc(wr_q) : wr_q;
        rd_d  = pop  ? ptr_inc(rd_q) : rd_q;
        cnt_d = cnt_q;
        case ({push, pop})
            2'b10:   cnt_d = cnt_q + 1'b1;
            2'b01:   cnt_d = cnt_q - 1'b1;
            default: cnt_d = cnt_q;
        endcase
        if (issue) fetch_pc_d = fetch_pc_q + ADDR_W'(4);
        if (redirect) begin
            fetch_pc_d = {redirect_pc[ADDR_W-1:2], 2'b00};
            tvld_d     = '0;
            wr_d       = '0;
            rd_d       = '0;
            cnt_d      = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_pc_q <= RESET_PC;
            tvld_q     <= '0;
            wr_q       <= '0;
            rd_q       <= '0;
            cnt_q      <= '0;
        end else begin
            fetch_pc_q <= fetch_pc_d;
            tvld_q     <= tvld_d;
            wr_q       <= wr_d;
            rd_q       <= rd_d;
            cnt_q      <= cnt_d;
        end
    end

    // Tag PCs and FIFO payload need no reset: they are only observed behind a valid bit.
    always_ff @(posedge clk) begin
        tpc_q <= tpc_d;
        if (push) begin
            mem_instr[wr_q] <= imem_rdata;
            mem_pc[wr_q]    <= tpc_q[LAT-1];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && push && !pop) assert (cnt_q != LW'(DEPTH));
    end

    assign imem_en   = issue;
    assign imem_addr = fetch_pc_q;
    assign out_instr = out_valid ? mem_instr[rd_q] : '0;
    assign out_pc    = out_valid ? mem_pc[rd_q] : '0;
    assign out_pc4   = out_pc + ADDR_W'(4);
    assign level     = cnt_q;

endmodule
